// File: rtl/pc_pkg.sv
// Shared encodings for the PC sequencer: branch condition codes, ALU flag
// bit positions and the sequencer state enum.
package pc_pkg;

    // CondFlags arrives as {EQ,NE,LT,GE,LTU,GEU}, so EQ is the MSB.
    localparam int FLAG_GEU  = 0;
    localparam int FLAG_LTU  = 1;
    localparam int FLAG_GE   = 2;
    localparam int FLAG_LT   = 3;
    localparam int FLAG_NE   = 4;
    localparam int FLAG_EQ   = 5;
    localparam int NUM_FLAGS = 6;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_RSV2 = 3'd2,
        BR_RSV3 = 3'd3,
        BR_LT   = 3'd4,
        BR_GE   = 3'd5,
        BR_LTU  = 3'd6,
        BR_GEU  = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_FAULT
    } pc_state_e;

endpackage

// File: rtl/pc_branch_eval.sv
// Combinational branch-taken decode: conditional test on the selected ALU
// flag, or an unconditional jump.
module pc_branch_eval
    import pc_pkg::*;
(
    input  logic [NUM_FLAGS-1:0] CondFlags,
    input  logic [2:0]           BranchType,
    input  logic                 TestBranch,
    input  logic                 AlwaysBranch,
    output logic                 taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (br_type_e'(BranchType))
            BR_EQ:   cond = CondFlags[FLAG_EQ];
            BR_NE:   cond = CondFlags[FLAG_NE];
            BR_LT:   cond = CondFlags[FLAG_LT];
            BR_GE:   cond = CondFlags[FLAG_GE];
            BR_LTU:  cond = CondFlags[FLAG_LTU];
            BR_GEU:  cond = CondFlags[FLAG_GEU];
            default: cond = 1'b0;
        endcase
        taken = (TestBranch & cond) | AlwaysBranch;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot, sequential fetch, branches, traps and a
// misaligned-target fault state. Define RV_COMPRESSED_EN for 16-bit
// instruction support (2-byte increments, no alignment fault).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VEC = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_FLAGS-1:0] CondFlags,
    input  logic                 TestBranch,
    input  logic                 AlwaysBranch,
    input  logic                 AbsoluteBranch,
    input  logic [2:0]           BranchType,
    input  logic [DATA_W-1:0]    BranchAddr,
    input  logic                 InsLen16,
    input  logic                 Trap,
    input  logic                 TrapRet,
    input  logic [DATA_W-1:0]    TrapVec,
    input  logic                 FetchReady,
    output logic [DATA_W-1:0]    ProgAddr,
    output logic [DATA_W-1:0]    Epc,
    output logic                 FetchValid,
    output logic                 MisalignErr
);

    pc_state_e         state, state_n;
    logic [DATA_W-1:0] pc_n, epc_n;
    logic [DATA_W-1:0] inc, seq_addr, target_raw, target;
    logic              taken, misalign;

    pc_branch_eval u_branch_eval (
        .CondFlags    (CondFlags),
        .BranchType   (BranchType),
        .TestBranch   (TestBranch),
        .AlwaysBranch (AlwaysBranch),
        .taken        (taken)
    );

    assign target_raw = AbsoluteBranch ? BranchAddr : ProgAddr + BranchAddr;
    assign target     = {target_raw[DATA_W-1:1], 1'b0};

`ifdef RV_COMPRESSED_EN
    assign inc      = InsLen16 ? DATA_W'(2) : DATA_W'(4);
    assign misalign = 1'b0;
`else
    logic unused_inslen16;
    assign unused_inslen16 = InsLen16;
    assign inc      = DATA_W'(4);
    assign misalign = target[1];
`endif

    assign seq_addr = ProgAddr + inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_BOOT;
            ProgAddr <= RESET_VEC;
            Epc      <= '0;
        end else begin
            state    <= state_n;
            ProgAddr <= pc_n;
            Epc      <= epc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = ProgAddr;
        epc_n       = Epc;
        FetchValid  = (state == ST_FETCH);
        MisalignErr = (state == ST_FAULT);
        // Trap wins everywhere, even while stalled or faulted.
        if (Trap) begin
            pc_n    = TrapVec;
            epc_n   = ProgAddr;
            state_n = ST_FETCH;
        end else begin
            case (state)
                ST_BOOT:  state_n = ST_FETCH;
                ST_FETCH: begin
                    if (TrapRet) begin
                        pc_n = Epc;
                    end else if (FetchReady) begin
                        if (taken) begin
                            if (misalign) state_n = ST_FAULT;
                            else          pc_n    = target;
                        end else begin
                            pc_n = seq_addr;
                        end
                    end
                end
                ST_FAULT: state_n = ST_FAULT;
                default:  state_n = ST_BOOT;
            endcase
        end
    end

endmodule
